wave_controller: RTL and testbench
==================================

WAVE_CONTROLLER -- requirements
Module: wave_controller

Interface
REQ-001 Params: START_LIVES default 3, number of lives at game start; CLEAR_FRAMES default 120, wave-clear pause length in frames; DEATH_FRAMES default 90, death pause length in frames.
REQ-002 Params: BASE_SPEED default 1, alien speed on wave 0; MAX_SPEED default 8, upper limit on speed; CNT_W default $clog2(NUM_ROWS*NUM_COLS+1), width of the alien count.
REQ-003 Ports (one per line):
  pixel_clk  in  1  sole clock.
  rst  in  1  asynchronous, active-high reset.
  fsync  in  1  one-cycle start-of-frame strobe.
  start_btn  in  1  level input, already debounced and synchronised.
  alien_hit  in  1  level input from the alien group hit output.
  aliens_remaining  in  CNT_W  live alien count.
  player_hit  in  1  one-cycle pulse when the player is struck.
  invaded  in  1  level input, aliens have reached the player row.
  speed  out  8  alien group speed.
  wave_rst  out  1  one-cycle pulse that resets the alien group.
  play_en  out  1  high only in PLAY.
  state  out  3  state encoding.
  score_bcd  out  16  four BCD digits.
  lives  out  2  lives remaining.
  wave  out  4  wave number.

Function
REQ-004 States: IDLE, PLAY, WAVE_CLEAR, DYING, GAME_OVER; the encoding is the state_t enum in params.
REQ-005 IDLE -> PLAY on a start_btn rising edge; same edge: score_bcd=0, lives=START_LIVES, wave=0.
REQ-006 PLAY -> GAME_OVER immediately when invaded=1, regardless of lives.
REQ-007 PLAY -> WAVE_CLEAR on an fsync cycle with aliens_remaining==0; aliens_remaining is sampled only on fsync cycles.
REQ-008 PLAY -> DYING on player_hit when lives>1; lives decrements on that cycle.
REQ-009 PLAY -> GAME_OVER on player_hit when lives==1; lives becomes 0.
REQ-010 Priority within a cycle: invaded > wave clear > player_hit; a lower-priority event on the same cycle is dropped.
REQ-011 WAVE_CLEAR: frame timer loads CLEAR_FRAMES on entry, decrements on each fsync, and the FSM exits on the fsync where the timer==1 (exactly CLEAR_FRAMES fsyncs).
REQ-012 WAVE_CLEAR exit: wave increments, saturating at 15, and the FSM returns to PLAY.
REQ-013 DYING: same timer scheme with DEATH_FRAMES; exits to PLAY with no wave_rst, so alien positions persist.
REQ-014 GAME_OVER -> PLAY on a start_btn rising edge, with the same resets as REQ-005.
REQ-015 wave_rst pulses exactly one cycle, on the cycle PLAY is entered from IDLE, WAVE_CLEAR or GAME_OVER.
REQ-016 Score: +10 (tens digit +1 with BCD carry) on each alien_hit rising edge while in PLAY.
REQ-017 Score saturates at 9990; a hit at 9990 leaves the score unchanged.
REQ-018 An alien_hit held high for several cycles scores once; the edge detector runs in all states, but only edges in PLAY score.
REQ-019 Score holds in WAVE_CLEAR, DYING and GAME_OVER, and clears only on game start.
REQ-020 speed is registered and equals min(BASE_SPEED + wave, MAX_SPEED), plus 1 when aliens_remaining <= NUM_ROWS*NUM_COLS/4 and aliens_remaining > 0.
REQ-021 The result of REQ-020 is capped at MAX_SPEED and updates on fsync only.
REQ-022 Arithmetic is unsigned; speed is computed at 9 bits before capping, so no wrap-around is possible.

Reset
REQ-023 Asynchronous assertion of rst forces: state=IDLE, score_bcd=0, lives=START_LIVES, wave=0, speed=BASE_SPEED, wave_rst=0, play_en=0, timer=0, edge-detect flops=0.
REQ-024 rst mid-operation, including mid-pause, abandons all activity; the first start_btn edge after release behaves as REQ-005.
REQ-025 A start_btn held high through rst release does not start a game; a new rising edge is required.

Structure
REQ-026 state_t, START_LIVES, CLEAR_FRAMES, DEATH_FRAMES, BASE_SPEED and MAX_SPEED are defined in package params alongside NUM_ROWS and NUM_COLS.
REQ-027 The four-digit saturating BCD incrementer is a sub-module named bcd_score; the FSM, timer and speed logic stay in wave_controller.

Verification
REQ-028 rst, then start_btn 0->1: the cycle after the edge shows state=PLAY, wave_rst=1 for one cycle, lives=3, score_bcd=16'h0000.
REQ-029 In PLAY, alien_hit held high 5 cycles, then 2 more separate pulses: score_bcd=16'h0030.
REQ-030 Score preset via 999 hits to 16'h9990, then 1 more hit: stays 16'h9990.
REQ-031 aliens_remaining=0 asserted between fsyncs: WAVE_CLEAR at the next fsync; PLAY after 120 further fsyncs with wave=1, wave_rst pulse, speed=2 at the following fsync.
REQ-032 player_hit three times with DEATH_FRAMES elapsed between hits: lives 3->2->1->0, state GAME_OVER after the third hit; no wave_rst on either DYING exit.
REQ-033 invaded and player_hit on the same cycle with lives=3: GAME_OVER, lives stays 3; rst asserted asynchronously during WAVE_CLEAR returns all outputs to the REQ-023 values before the next clock edge.

Source files
------------

// File: rtl/wave_controller_pkg.sv
// Shared definitions for the wave controller slice.
//   state_t       : FSM state encoding, also driven onto the 3-bit state output.
//   NUM_ROWS/COLS : alien grid geometry (sets alien count width and "few left" threshold).
//   START_LIVES, CLEAR_FRAMES, DEATH_FRAMES, BASE_SPEED, MAX_SPEED : default tuning.
//   SCORE_MAX_BCD : saturation point of the four-digit BCD score.
package params;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PLAY       = 3'd1,
        WAVE_CLEAR = 3'd2,
        DYING      = 3'd3,
        GAME_OVER  = 3'd4
    } state_t;

    localparam int unsigned NUM_ROWS     = 5;
    localparam int unsigned NUM_COLS     = 11;
    localparam int unsigned START_LIVES  = 3;
    localparam int unsigned CLEAR_FRAMES = 120;
    localparam int unsigned DEATH_FRAMES = 90;
    localparam int unsigned BASE_SPEED   = 1;
    localparam int unsigned MAX_SPEED    = 8;

    localparam logic [15:0] SCORE_MAX_BCD = 16'h9990;

endpackage

// File: rtl/wave_controller_bcd_score.sv
// bcd_score: combinational four-digit BCD "+10" incrementer with saturation.
//   score_in  [15:0] : current score, four BCD digits (units digit always 0).
//   score_out [15:0] : score_in plus ten, or score_in unchanged once at 9990.
module bcd_score
    import params::*;
(
    input  logic [15:0] score_in,
    output logic [15:0] score_out
);

    always_comb begin
        score_out = score_in;
        if (score_in[15:4] != SCORE_MAX_BCD[15:4]) begin
            if (score_in[7:4] != 4'd9) begin
                score_out[7:4] = score_in[7:4] + 4'd1;
            end else begin
                score_out[7:4] = '0;
                if (score_in[11:8] != 4'd9) begin
                    score_out[11:8] = score_in[11:8] + 4'd1;
                end else begin
                    // Thousands cannot be 9 here: 999x was excluded above.
                    score_out[11:8]  = '0;
                    score_out[15:12] = score_in[15:12] + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/wave_controller.sv
// wave_controller: game-flow FSM for the invaders game.
//   pixel_clk, rst        : clock, asynchronous active-high reset.
//   fsync                 : one-cycle start-of-frame strobe (pause timers, speed update).
//   start_btn             : debounced level; rising edge starts a game from IDLE/GAME_OVER.
//   alien_hit             : level; each rising edge in PLAY scores 10.
//   aliens_remaining      : live alien count, sampled on fsync.
//   player_hit, invaded   : player struck pulse / aliens reached player row level.
//   speed                 : alien group speed, refreshed on fsync.
//   wave_rst              : one-cycle pulse when PLAY is entered from IDLE, WAVE_CLEAR, GAME_OVER.
//   play_en               : high while in PLAY.
//   state, score_bcd, lives, wave : status outputs.
module wave_controller
    import params::*;
#(
    parameter int unsigned START_LIVES  = params::START_LIVES,
    parameter int unsigned CLEAR_FRAMES = params::CLEAR_FRAMES,
    parameter int unsigned DEATH_FRAMES = params::DEATH_FRAMES,
    parameter int unsigned BASE_SPEED   = params::BASE_SPEED,
    parameter int unsigned MAX_SPEED    = params::MAX_SPEED,
    parameter int unsigned CNT_W        = $clog2(NUM_ROWS*NUM_COLS+1)
) (
    input  logic             pixel_clk,
    input  logic             rst,
    input  logic             fsync,
    input  logic             start_btn,
    input  logic             alien_hit,
    input  logic [CNT_W-1:0] aliens_remaining,
    input  logic             player_hit,
    input  logic             invaded,
    output logic [7:0]       speed,
    output logic             wave_rst,
    output logic             play_en,
    output logic [2:0]       state,
    output logic [15:0]      score_bcd,
    output logic [1:0]       lives,
    output logic [3:0]       wave
);

    localparam int unsigned TMR_MAX = (CLEAR_FRAMES > DEATH_FRAMES) ? CLEAR_FRAMES : DEATH_FRAMES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned QUARTER = NUM_ROWS * NUM_COLS / 4;

    state_t             state_q, state_d;
    logic [15:0]        score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic [3:0]         wave_q, wave_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [7:0]         speed_q, speed_d;
    logic               wave_rst_q, wave_rst_d;
    logic               start_prev_q, start_prev_d;
    logic               start_arm_q, start_arm_d;
    logic               hit_prev_q, hit_prev_d;

    logic [15:0]        score_inc;
    logic               start_rise;
    logic               hit_rise;
    logic [8:0]         spd_raw;

    bcd_score u_bcd_score (
        .score_in  (score_q),
        .score_out (score_inc)
    );

    // Speed target, computed 9 bits wide so BASE_SPEED + wave cannot wrap.
    always_comb begin
        spd_raw = 9'(BASE_SPEED) + 9'(wave_q);
        if (spd_raw > 9'(MAX_SPEED)) spd_raw = 9'(MAX_SPEED);
        if (aliens_remaining != '0 && aliens_remaining <= CNT_W'(QUARTER)) spd_raw = spd_raw + 9'd1;
        if (spd_raw > 9'(MAX_SPEED)) spd_raw = 9'(MAX_SPEED);
    end

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        lives_d      = lives_q;
        wave_d       = wave_q;
        timer_d      = timer_q;
        speed_d      = speed_q;
        wave_rst_d   = 1'b0;
        start_prev_d = start_btn;
        hit_prev_d   = alien_hit;
        // start_arm is only set once start_btn has been seen low after reset,
        // so a button held through reset release cannot start a game.
        start_arm_d  = start_arm_q | ~start_btn;
        start_rise   = start_btn & ~start_prev_q & start_arm_q;
        hit_rise     = alien_hit & ~hit_prev_q;

        if (fsync) speed_d = spd_raw[7:0];

        case (state_q)
            IDLE, GAME_OVER: begin
                if (start_rise) begin
                    state_d    = PLAY;
                    score_d    = '0;
                    lives_d    = 2'(START_LIVES);
                    wave_d     = '0;
                    wave_rst_d = 1'b1;
                end
            end
            PLAY: begin
                if (hit_rise) score_d = score_inc;
                // Priority: invasion, then wave clear, then player hit.
                if (invaded) begin
                    state_d = GAME_OVER;
                end else if (fsync && aliens_remaining == '0) begin
                    state_d = WAVE_CLEAR;
                    timer_d = TMR_W'(CLEAR_FRAMES);
                end else if (player_hit) begin
                    if (lives_q > 2'd1) begin
                        state_d = DYING;
                        lives_d = lives_q - 2'd1;
                        timer_d = TMR_W'(DEATH_FRAMES);
                    end else begin
                        state_d = GAME_OVER;
                        lives_d = '0;
                    end
                end
            end
            WAVE_CLEAR: begin
                if (fsync) begin
                    if (timer_q == TMR_W'(1)) begin
                        state_d    = PLAY;
                        timer_d    = '0;
                        wave_rst_d = 1'b1;
                        if (wave_q != '1) wave_d = wave_q + 4'd1;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
            end
            DYING: begin
                // Aliens keep their positions after a death, so no wave_rst.
                if (fsync) begin
                    if (timer_q == TMR_W'(1)) begin
                        state_d = PLAY;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            score_q      <= '0;
            lives_q      <= 2'(START_LIVES);
            wave_q       <= '0;
            timer_q      <= '0;
            speed_q      <= 8'(BASE_SPEED);
            wave_rst_q   <= 1'b0;
            start_prev_q <= 1'b0;
            start_arm_q  <= 1'b0;
            hit_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            wave_q       <= wave_d;
            timer_q      <= timer_d;
            speed_q      <= speed_d;
            wave_rst_q   <= wave_rst_d;
            start_prev_q <= start_prev_d;
            start_arm_q  <= start_arm_d;
            hit_prev_q   <= hit_prev_d;
        end
    end

    assign speed     = speed_q;
    assign wave_rst  = wave_rst_q;
    assign play_en   = (state_q == PLAY);
    assign state     = state_q;
    assign score_bcd = score_q;
    assign lives     = lives_q;
    assign wave      = wave_q;

endmodule

// File: tb/tb_wave_controller.sv
// Bench for wave_controller: directed scenarios followed by randomized play,
// every cycle compared against a game-rule model (decimal score, frame counts).
module tb_wave_controller;
    import params::*;

    localparam int CNT_W   = $clog2(NUM_ROWS*NUM_COLS+1);
    localparam int N_ALIEN = NUM_ROWS*NUM_COLS;

    logic             pixel_clk;
    logic             rst;
    logic             fsync;
    logic             start_btn;
    logic             alien_hit;
    logic [CNT_W-1:0] aliens_remaining;
    logic             player_hit;
    logic             invaded;
    logic [7:0]       speed;
    logic             wave_rst;
    logic             play_en;
    logic [2:0]       state;
    logic [15:0]      score_bcd;
    logic [1:0]       lives;
    logic [3:0]       wave;

    wave_controller dut (
        .pixel_clk        (pixel_clk),
        .rst              (rst),
        .fsync            (fsync),
        .start_btn        (start_btn),
        .alien_hit        (alien_hit),
        .aliens_remaining (aliens_remaining),
        .player_hit       (player_hit),
        .invaded          (invaded),
        .speed            (speed),
        .wave_rst         (wave_rst),
        .play_en          (play_en),
        .state            (state),
        .score_bcd        (score_bcd),
        .lives            (lives),
        .wave             (wave)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    state_t m_state;
    int     m_score;      // plain decimal points
    int     m_lives;
    int     m_wave;
    int     m_frames;     // fsyncs seen since entering a pause
    int     m_speed;
    bit     m_wave_rst;
    bit     m_start_last; // last observed start_btn; 1 after reset so a held button needs a new edge
    bit     m_hit_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_state      = IDLE;
        m_score      = 0;
        m_lives      = START_LIVES;
        m_wave       = 0;
        m_frames     = 0;
        m_speed      = BASE_SPEED;
        m_wave_rst   = 1'b0;
        m_start_last = 1'b1;
        m_hit_last   = 1'b0;
    endtask

    task automatic model_step();
        bit start_edge, hit_edge;
        int s;
        start_edge   = start_btn && !m_start_last;
        hit_edge     = alien_hit && !m_hit_last;
        m_start_last = start_btn;
        m_hit_last   = alien_hit;
        m_wave_rst   = 1'b0;

        if (fsync) begin
            s = BASE_SPEED + m_wave;
            if (s > MAX_SPEED) s = MAX_SPEED;
            if (aliens_remaining > 0 && aliens_remaining <= N_ALIEN / 4) s = s + 1;
            if (s > MAX_SPEED) s = MAX_SPEED;
            m_speed = s;
        end

        if (m_state == IDLE || m_state == GAME_OVER) begin
            if (start_edge) begin
                m_state = PLAY; m_score = 0; m_lives = START_LIVES; m_wave = 0; m_wave_rst = 1'b1;
            end
        end else if (m_state == PLAY) begin
            if (hit_edge && m_score + 10 <= 9990) m_score = m_score + 10;
            if (invaded) begin
                m_state = GAME_OVER;
            end else if (fsync && aliens_remaining == 0) begin
                m_state = WAVE_CLEAR; m_frames = 0;
            end else if (player_hit) begin
                m_lives = m_lives - 1;
                if (m_lives > 0) begin
                    m_state = DYING; m_frames = 0;
                end else begin
                    m_state = GAME_OVER;
                end
            end
        end else if (m_state == WAVE_CLEAR) begin
            if (fsync) begin
                m_frames++;
                if (m_frames == CLEAR_FRAMES) begin
                    m_state = PLAY; m_wave_rst = 1'b1;
                    if (m_wave < 15) m_wave++;
                end
            end
        end else if (m_state == DYING) begin
            if (fsync) begin
                m_frames++;
                if (m_frames == DEATH_FRAMES) m_state = PLAY;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".state"},    32'(state),     32'(m_state));
        check({tag, ".score"},    32'(score_bcd), 32'(to_bcd(m_score)));
        check({tag, ".lives"},    32'(lives),     32'(m_lives));
        check({tag, ".wave"},     32'(wave),      32'(m_wave));
        check({tag, ".speed"},    32'(speed),     32'(m_speed));
        check({tag, ".wave_rst"}, 32'(wave_rst),  32'(m_wave_rst));
        check({tag, ".play_en"},  32'(play_en),   32'(m_state == PLAY));
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        compare_all("cyc");
    endtask

    task automatic frame();
        fsync = 1'b1; tick();
        fsync = 1'b0; tick();
    endtask

    task automatic hit_pulse();
        alien_hit = 1'b1; tick();
        alien_hit = 1'b0; tick();
    endtask

    task automatic start_game();
        start_btn = 1'b0; tick();
        start_btn = 1'b1; tick();
    endtask

    initial begin
        rst = 1'b1; fsync = 1'b0; start_btn = 1'b0; alien_hit = 1'b0;
        aliens_remaining = CNT_W'(N_ALIEN); player_hit = 1'b0; invaded = 1'b0;
        model_reset();
        #1;
        compare_all("reset");
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Game start
        start_btn = 1'b1; tick();
        check("start.state", 32'(state), 32'(PLAY));
        check("start.wave_rst", 32'(wave_rst), 32'd1);
        check("start.lives", 32'(lives), 32'd3);
        check("start.score", 32'(score_bcd), 32'h0000);
        tick();
        check("start.wave_rst_one", 32'(wave_rst), 32'd0);
        start_btn = 1'b0;

        // Held hit scores once, then two separate pulses
        alien_hit = 1'b1; repeat (5) tick();
        alien_hit = 1'b0; tick();
        repeat (2) hit_pulse();
        check("hit.held", 32'(score_bcd), 32'h0030);

        // Drive score to saturation
        repeat (996) hit_pulse();
        check("score.9990", 32'(score_bcd), 32'h9990);
        hit_pulse();
        check("score.sat", 32'(score_bcd), 32'h9990);

        // Wave clear
        aliens_remaining = '0;
        repeat (3) tick();
        check("clear.wait", 32'(state), 32'(PLAY));
        fsync = 1'b1; tick(); fsync = 1'b0;
        check("clear.enter", 32'(state), 32'(WAVE_CLEAR));
        aliens_remaining = CNT_W'(N_ALIEN);
        tick();
        repeat (CLEAR_FRAMES - 1) frame();
        check("clear.hold", 32'(state), 32'(WAVE_CLEAR));
        fsync = 1'b1; tick(); fsync = 1'b0;
        check("clear.exit", 32'(state), 32'(PLAY));
        check("clear.wave", 32'(wave), 32'd1);
        check("clear.wave_rst", 32'(wave_rst), 32'd1);
        tick();
        fsync = 1'b1; tick(); fsync = 1'b0;
        check("clear.speed", 32'(speed), 32'd2);
        tick();

        // Three deaths
        for (int i = 0; i < 3; i++) begin
            player_hit = 1'b1; tick(); player_hit = 1'b0;
            check("death.lives", 32'(lives), 32'(2 - i));
            if (i < 2) begin
                check("death.state", 32'(state), 32'(DYING));
                tick();
                repeat (DEATH_FRAMES - 1) frame();
                fsync = 1'b1; tick(); fsync = 1'b0;
                check("death.exit", 32'(state), 32'(PLAY));
                check("death.no_wave_rst", 32'(wave_rst), 32'd0);
                tick();
            end else begin
                check("death.over", 32'(state), 32'(GAME_OVER));
            end
        end

        // invaded beats player_hit
        start_game();
        check("restart.state", 32'(state), 32'(PLAY));
        invaded = 1'b1; player_hit = 1'b1; tick();
        invaded = 1'b0; player_hit = 1'b0;
        check("invade.state", 32'(state), 32'(GAME_OVER));
        check("invade.lives", 32'(lives), 32'd3);

        // Async reset mid wave-clear
        start_game();
        aliens_remaining = '0; frame();
        aliens_remaining = CNT_W'(N_ALIEN);
        check("arst.pre", 32'(state), 32'(WAVE_CLEAR));
        repeat (10) frame();
        #2 rst = 1'b1;
        #1 model_reset();
        compare_all("arst");
        check("arst.state", 32'(state), 32'(IDLE));
        tick();
        rst = 1'b0;

        // Start held through reset release does not start
        start_btn = 1'b1; rst = 1'b1; tick(); tick();
        rst = 1'b0; repeat (3) tick();
        check("held.idle", 32'(state), 32'(IDLE));
        start_game();
        check("held.start", 32'(state), 32'(PLAY));

        // Randomized play
        for (int i = 0; i < 40000; i++) begin
            fsync      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) alien_hit = ~alien_hit;
            player_hit = ($urandom_range(0, 60) == 0);
            invaded    = ($urandom_range(0, 1500) == 0);
            if ($urandom_range(0, 30) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 40) == 0)
                aliens_remaining = ($urandom_range(0, 3) == 0) ? '0 : CNT_W'($urandom_range(0, N_ALIEN));
            rst        = ($urandom_range(0, 5000) == 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
